// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state and Booth digit-select encoding.
//   state_t          encoder FSM states
//   SEL_*            3-bit digit selects, packed as {neg, dbl, sngl}
package booth_pkg;
    typedef enum logic {IDLE, ENCODE} state_t;
    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_P1   = 3'b001;
    localparam logic [2:0] SEL_P2   = 3'b010;
    localparam logic [2:0] SEL_M1   = 3'b101;
    localparam logic [2:0] SEL_M2   = 3'b110;
endpackage

// File: rtl/booth_radix4_encoder_if.sv
// booth_radix4_encoder_if: load and digit handshakes of the radix-4 Booth encoder.
//   load side : load_valid, load_ready, multiplier[N-1:0]
//   digit side: dig_valid, dig_ready, sngl, dbl, neg, dig_idx[IDXW-1:0], last
//   master = upstream/downstream driver, slave = encoder
interface booth_radix4_encoder_if #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N / 2)
);
    logic            load_valid;
    logic            load_ready;
    logic [N-1:0]    multiplier;
    logic            dig_valid;
    logic            dig_ready;
    logic            sngl;
    logic            dbl;
    logic            neg;
    logic [IDXW-1:0] dig_idx;
    logic            last;
    modport master (
        output load_valid, multiplier, dig_ready,
        input  load_ready, dig_valid, sngl, dbl, neg, dig_idx, last
    );
    modport slave (
        input  load_valid, multiplier, dig_ready,
        output load_ready, dig_valid, sngl, dbl, neg, dig_idx, last
    );
endinterface

// File: rtl/booth_digit_sel.sv
// booth_digit_sel: maps Booth bits {y[2i+1], y[2i], y[2i-1]} to a digit select.
//   y    : 3 overlapping multiplier bits
//   sngl : |d| == 1, dbl : |d| == 2, neg : d < 0 (111 yields +0, never -0)
module booth_digit_sel (
    input  logic [2:0] y,
    output logic       sngl,
    output logic       dbl,
    output logic       neg
);
    assign sngl = y[1] ^ y[0];
    assign dbl  = (y[2] & ~y[1] & ~y[0]) | (~y[2] & y[1] & y[0]);
    assign neg  = y[2] & ~(y[1] & y[0]);
endmodule

// File: rtl/booth_radix4_encoder.sv
// booth_radix4_encoder: sequential radix-4 Booth encoder, one digit per handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load handshake (multiplier in) and digit handshake (select triple out)
module booth_radix4_encoder
    import booth_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N / 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_radix4_encoder_if.slave bus
);
    state_t          state, state_nx;
    logic [N:0]      sr;
    logic [IDXW-1:0] idx;
    logic            enc, last, load_fire, dig_fire, sngl, dbl, neg;

    assign enc       = state == ENCODE;
    assign last      = enc & (idx == IDXW'(N / 2 - 1));
    assign load_fire = bus.load_valid & ~enc;
    assign dig_fire  = enc & bus.dig_ready;

    booth_digit_sel u_sel (.y(sr[2:0]), .sngl(sngl), .dbl(dbl), .neg(neg));

    // Outputs depend only on registered state and shift register.
    assign bus.load_ready = ~enc;
    assign bus.dig_valid  = enc;
    assign bus.sngl       = enc & sngl;
    assign bus.dbl        = enc & dbl;
    assign bus.neg        = enc & neg;
    assign bus.dig_idx    = idx;
    assign bus.last       = last;

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = load_fire ? ENCODE : IDLE;
        else
            state_nx = (dig_fire & last) ? IDLE : ENCODE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (load_fire) begin
                sr  <= {bus.multiplier, 1'b0};
                idx <= '0;
            end else if (dig_fire) begin
                // Index returns to 0 after the last digit so IDLE shows a clean index.
                sr  <= sr >> 2;
                idx <= last ? '0 : idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_booth_radix4_encoder.sv
// tb_booth_radix4_encoder: directed and randomized checks of the radix-4 Booth encoder.
module tb_booth_radix4_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_radix4_encoder_if #(.N(8)) bus ();
    booth_radix4_encoder #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    // {dig_valid, sngl, dbl, neg, dig_idx, last, load_ready}
    logic [7:0] obs;
    assign obs = {bus.dig_valid, bus.sngl, bus.dbl, bus.neg, bus.dig_idx, bus.last, bus.load_ready};

    localparam logic [7:0] IDLE_V = 8'h01;

    // Expected observation for digit i with select triple t = {sngl, dbl, neg}.
    function automatic logic [7:0] ev(input logic [2:0] t, input int i);
        return {1'b1, t, 2'(i), i == 3, 1'b0};
    endfunction

    task automatic load(input logic [7:0] m);
        bus.load_valid = 1'b1;
        bus.multiplier = m;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL reset_async got=%b exp=%b", obs, IDLE_V); end
        @(posedge clk); #1;
        checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL reset_held got=%b exp=%b", obs, IDLE_V); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, IDLE_V); end
    endtask

    task automatic test_patterns;
        logic [7:0]  ms [4] = '{8'h5A, 8'hFF, 8'h80, 8'h7F};
        // digit i triple at [3*i +: 3]; 011=-2 101=-1 010=+2 100=+1 000=0
        logic [11:0] es [4] = '{12'b100_010_101_011, 12'b000_000_000_101,
                                12'b011_000_000_000, 12'b010_000_000_101};
        bus.dig_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            load(ms[w]);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs !== ev(es[w][3*i +: 3], i)) begin
                    failures++;
                    $display("FAIL pattern_%h_d%0d got=%b exp=%b", ms[w], i, obs, ev(es[w][3*i +: 3], i));
                end
                @(posedge clk); #1;
            end
            checks++;
            if (obs !== IDLE_V) begin failures++; $display("FAIL pattern_%h_idle got=%b exp=%b", ms[w], obs, IDLE_V); end
        end
    endtask

    task automatic test_stall;
        bus.dig_ready = 1'b1;
        load(8'h5A);
        checks++;
        if (obs !== ev(3'b011, 0)) begin failures++; $display("FAIL stall_d0 got=%b exp=%b", obs, ev(3'b011, 0)); end
        @(posedge clk); #1;
        bus.dig_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs !== ev(3'b101, 1)) begin failures++; $display("FAIL stall_hold%0d got=%b exp=%b", k, obs, ev(3'b101, 1)); end
            if (k == 2) begin
                bus.load_valid = 1'b1;
                bus.multiplier = 8'h00;
            end
            @(posedge clk); #1;
            bus.load_valid = 1'b0;
        end
        checks++;
        if (obs !== ev(3'b101, 1)) begin failures++; $display("FAIL stall_end got=%b exp=%b", obs, ev(3'b101, 1)); end
        bus.dig_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== ev(3'b010, 2)) begin failures++; $display("FAIL stall_d2 got=%b exp=%b", obs, ev(3'b010, 2)); end
        @(posedge clk); #1;
        checks++;
        if (obs !== ev(3'b100, 3)) begin failures++; $display("FAIL stall_d3 got=%b exp=%b", obs, ev(3'b100, 3)); end
        @(posedge clk); #1;
        checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL stall_idle got=%b exp=%b", obs, IDLE_V); end
    endtask

    task automatic test_reset_mid;
        logic [11:0] e80 = 12'b011_000_000_000;
        logic [11:0] e7f = 12'b010_000_000_101;
        bus.dig_ready = 1'b1;
        load(8'h7F);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== ev(e7f[3*i +: 3], i)) begin failures++; $display("FAIL midrst_pre_d%0d got=%b exp=%b", i, obs, ev(e7f[3*i +: 3], i)); end
            if (i < 2) begin @(posedge clk); #1; end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL midrst_async got=%b exp=%b", obs, IDLE_V); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL midrst_after got=%b exp=%b", obs, IDLE_V); end
        load(8'h80);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== ev(e80[3*i +: 3], i)) begin failures++; $display("FAIL midrst_80_d%0d got=%b exp=%b", i, obs, ev(e80[3*i +: 3], i)); end
            @(posedge clk); #1;
        end
        checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL midrst_idle got=%b exp=%b", obs, IDLE_V); end
    endtask

    task automatic test_back_to_back;
        int nxt = 0;
        int done = 0;
        int sum = 0;
        int cnt = 0;
        int cyc = 0;
        int d;
        logic signed [7:0] cur = '0;
        bus.load_valid = 1'b1;
        bus.multiplier = 8'h00;
        while (done < 256 && cyc < 20000) begin
            bus.dig_ready = 1'($urandom_range(0, 1));
            if (bus.load_valid && bus.load_ready) begin
                cur = 8'(nxt);
                nxt++;
                sum = 0;
                cnt = 0;
            end
            if (bus.dig_valid && bus.dig_ready) begin
                checks++;
                if (bus.sngl && bus.dbl) begin failures++; $display("FAIL b2b_excl m=%h idx=%0d got=11 exp=not both", cur, bus.dig_idx); end
                d = bus.dbl ? 2 : (bus.sngl ? 1 : 0);
                if (bus.neg) d = -d;
                sum += d * (1 << (2 * int'(bus.dig_idx)));
                cnt++;
                if (bus.last) begin
                    checks++;
                    if (sum != int'(cur) || cnt != 4) begin
                        failures++;
                        $display("FAIL b2b_sum m=%h got=%0d/%0d digits exp=%0d/4 digits", cur, sum, cnt, cur);
                    end
                    done++;
                end
            end
            @(posedge clk); #1;
            cyc++;
            bus.load_valid = nxt < 256;
            bus.multiplier = 8'(nxt);
        end
        bus.load_valid = 1'b0;
        checks++;
        if (done != 256) begin failures++; $display("FAIL b2b_timeout got=%0d words exp=256", done); end
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.multiplier = 8'h00;
        bus.dig_ready  = 1'b1;
        test_reset();
        test_patterns();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
